// File: rtl/serial_receiver64.sv
// serial_receiver64: MSB-first serial-to-parallel frame receiver with bit strobe,
// abort and a Valid/Ack holding-register handshake.
module serial_receiver64 #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             SerIn,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Ack,
  output logic [WIDTH-1:0] Out,
  output logic             Valid,
  output logic             Busy,
  output logic [6:0]       Count
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic last;
  assign shifted = {sr[WIDTH-2:0], SerIn};
  // Abort outranks the final bit, so a frame only completes when no abort is pending
  assign last = state == SHIFT && !Abort && En && Count == 7'(WIDTH - 1);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE  ? (Start ? SHIFT : IDLE) :
                state == SHIFT ? (Abort ? IDLE : last ? DONE : SHIFT) :
                state == DONE  ? (Ack ? IDLE : DONE) : IDLE;
  end
  always_comb begin
    Valid = state == DONE;
    Busy  = state == SHIFT;
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      sr    <= '0;
      Out   <= '0;
      Count <= '0;
    end else if (state == IDLE) begin
      if (Start) begin
        sr    <= '0;
        Count <= '0;
      end
    end else if (state == SHIFT) begin
      if (Abort) Count <= '0;
      else if (En) begin
        sr    <= shifted;
        Count <= Count + 7'd1;
        if (last) Out <= shifted;
      end
    end else if (state == DONE && Ack) Count <= '0;
endmodule

// File: tb/tb_serial_receiver64.sv
// tb_serial_receiver64: scoreboard bench for serial_receiver64 covering framing,
// strobe gating, abort, DONE hold, ack/start collision and asynchronous reset.
module tb_serial_receiver64;
  logic Clk = 0, Reset = 0, En = 0, SerIn = 0, Start = 0, Abort = 0, Ack = 0;
  logic [63:0] Out;
  logic Valid, Busy, valid_q = 0;
  logic [6:0] Count;
  logic [63:0] sb[$];
  logic [63:0] held;
  int tests = 0, fails = 0;

  serial_receiver64 #(.WIDTH(64)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .SerIn(SerIn), .Start(Start), .Abort(Abort),
    .Ack(Ack), .Out(Out), .Valid(Valid), .Busy(Busy), .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A rising Valid is the DUT producing a frame: pop the oldest expected frame
  always @(negedge Clk) begin
    if (Valid && !valid_q) begin
      if (sb.size() == 0) check("unexpected_frame", Out, 64'hx);
      else check("frame", Out, sb.pop_front());
    end
    valid_q = Valid;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic start_frame;
    Start = 1; En = 1'($urandom); SerIn = 1'($urandom);
    tick;
    Start = 0; En = 0;
    check("start_busy", Busy, 1);
    check("start_cnt", Count, 0);
  endtask

  task automatic shift_bits(input logic [63:0] v, input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      if (tog) begin
        En = 0; SerIn = 1'($urandom); Ack = 1;
        tick;
        Ack = 0;
        check("hold_cnt", Count, i);
      end
      En = 1; SerIn = v[63-i];
      tick;
      En = 0;
      check("cnt", Count, i + 1);
    end
  endtask

  task automatic frame(input logic [63:0] v, input bit tog);
    start_frame;
    sb.push_back(v);
    shift_bits(v, 64, tog);
    check("done_valid", Valid, 1);
    check("done_busy", Busy, 0);
    check("done_cnt", Count, 64);
    check("done_out", Out, v);
  endtask

  task automatic ack_frame;
    held = Out;
    Ack = 1;
    tick;
    Ack = 0;
    check("ack_valid", Valid, 0);
    check("ack_cnt", Count, 0);
    check("ack_out", Out, held);
  endtask

  initial begin
    #3;
    check("rst_out", Out, 0);
    check("rst_valid", Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_cnt", Count, 0);
    #9 Reset = 1;
    tick;
    Abort = 1; Ack = 1;
    tick;
    Abort = 0; Ack = 0;
    check("idle_abort_busy", Busy, 0);
    check("idle_ack_valid", Valid, 0);

    frame(64'hA5A5_0000_FFFF_1234, 0);
    ack_frame;
    frame(64'hA5A5_0000_FFFF_1234, 1);
    ack_frame;

    start_frame;
    shift_bits('1, 40, 0);
    Abort = 1;
    tick;
    Abort = 0;
    check("abort_busy", Busy, 0);
    check("abort_cnt", Count, 0);
    check("abort_valid", Valid, 0);
    check("abort_out", Out, 64'hA5A5_0000_FFFF_1234);
    frame(64'h0, 0);

    held = Out;
    for (int i = 0; i < 10; i++) begin
      En = 1'($urandom); SerIn = 1'($urandom); Start = 1'($urandom); Abort = 1'($urandom);
      tick;
      check("hold_out", Out, held);
      check("hold_valid", Valid, 1);
      check("hold_cnt64", Count, 64);
    end
    En = 0; Abort = 0;
    Ack = 1; Start = 1;
    tick;
    Ack = 0; Start = 0;
    check("ackstart_valid", Valid, 0);
    check("ackstart_busy", Busy, 0);
    tick;
    check("ackstart_nostart", Busy, 0);

    start_frame;
    shift_bits(64'hFFFF_FFFF_FFFF_FFFF, 29, 0);
    En = 1; SerIn = 1;
    #2 Reset = 0;
    #1;
    check("arst_valid", Valid, 0);
    check("arst_busy", Busy, 0);
    check("arst_cnt", Count, 0);
    check("arst_out", Out, 0);
    En = 0;
    tick;
    #2 Reset = 1;
    tick;
    check("post_rst_busy", Busy, 0);
    frame(64'h8000_0000_0000_0001, 0);
    ack_frame;

    held = Out;
    start_frame;
    shift_bits(64'hFFFF_0000_FFFF_0000, 63, 0);
    En = 1; SerIn = 0; Abort = 1;
    tick;
    En = 0; Abort = 0;
    check("lastabort_valid", Valid, 0);
    check("lastabort_busy", Busy, 0);
    check("lastabort_cnt", Count, 0);
    check("lastabort_out", Out, held);
    tick;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
